// File: rtl/mc_ctrl_fsm_pkg.sv
// ============================================================================
// Package  : mc_ctrl_fsm_pkg
// Brief    : State, opcode and datapath-control encodings shared by the
//            multicycle controller and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_HALT     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [3:0] c_op_rtype = 4'h0;
    localparam logic [3:0] c_op_itype = 4'h1;
    localparam logic [3:0] c_op_load  = 4'h2;
    localparam logic [3:0] c_op_store = 4'h3;
    localparam logic [3:0] c_op_beq   = 4'h4;
    localparam logic [3:0] c_op_bne   = 4'h5;
    localparam logic [3:0] c_op_jal   = 4'h6;
    localparam logic [3:0] c_op_halt  = 4'hF;

    localparam logic [1:0] c_alu_add   = 2'd0;
    localparam logic [1:0] c_alu_sub   = 2'd1;
    localparam logic [1:0] c_alu_funct = 2'd2;

    localparam logic [1:0] c_srcb_b      = 2'd0;
    localparam logic [1:0] c_srcb_two    = 2'd1;
    localparam logic [1:0] c_srcb_imm    = 2'd2;
    localparam logic [1:0] c_srcb_imm_sh = 2'd3;

    localparam logic [1:0] c_pcsrc_aluout = 2'd1;
    localparam logic [1:0] c_pcsrc_jump   = 2'd2;

    localparam logic [1:0] c_wbsel_aluout = 2'd0;
    localparam logic [1:0] c_wbsel_mdr    = 2'd1;
    localparam logic [1:0] c_wbsel_pc     = 2'd2;

    localparam logic [1:0] c_trap_none    = 2'd0;
    localparam logic [1:0] c_trap_illegal = 2'd1;
    localparam logic [1:0] c_trap_mem     = 2'd2;

    // rdy_gated: enables/done qualified by mem_ready; br_cond: pc_en qualified by zero
    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       mdr_en;
        logic       a_en;
        logic       b_en;
        logic       aluout_en;
        logic       rf_we;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       halted;
        logic       instr_done;
        logic       rdy_gated;
        logic       br_cond;
    } ctl_t;

    function automatic ctl_t ctl_decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = c_srcb_two;
                c.ir_en     = 1'b1;
                c.pc_en     = 1'b1;
                c.rdy_gated = 1'b1;
            end
            S_DECODE: begin
                c.a_en      = 1'b1;
                c.b_en      = 1'b1;
                c.aluout_en = 1'b1;
                c.alu_src_b = c_srcb_imm_sh;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = c_alu_funct;
                c.aluout_en = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_srcb_imm;
                c.alu_op    = c_alu_funct;
                c.aluout_en = 1'b1;
            end
            S_ALU_WB: begin
                c.rf_we      = 1'b1;
                c.wb_sel     = c_wbsel_aluout;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_srcb_imm;
                c.aluout_en = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.mdr_en    = 1'b1;
                c.rdy_gated = 1'b1;
            end
            S_MEM_WB: begin
                c.rf_we      = 1'b1;
                c.wb_sel     = c_wbsel_mdr;
                c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req    = 1'b1;
                c.mem_we     = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = 1'b1;
                c.rdy_gated  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = c_alu_sub;
                c.pc_src     = c_pcsrc_aluout;
                c.pc_en      = 1'b1;
                c.br_cond    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.rf_we      = 1'b1;
                c.wb_sel     = c_wbsel_pc;
                c.pc_en      = 1'b1;
                c.pc_src     = c_pcsrc_jump;
                c.instr_done = 1'b1;
            end
            S_HALT, S_TRAP: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module   : mc_wait_timer
// Brief    : Memory wait-state counter; expired flags the last permitted edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_n,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    // Expired one count early so the trap lands on the MEM_TIMEOUT-th waiting edge
    localparam logic [TO_W-1:0] c_limit = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    always_ff @(negedge clk_n or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Moore control FSM sequencing the multicycle 16-bit datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk_n,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       mdr_en,
    output logic       a_en,
    output logic       b_en,
    output logic       aluout_en,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic [1:0] trap_cause,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    ctl_t       r_ctl;
    logic [1:0] r_trap_cause;
    logic [1:0] w_trap_set;
    logic       w_expired;
    logic       w_clr;
    logic       w_inc;
    logic       w_rdy_ok;

    always_comb begin
        w_next     = r_state;
        w_trap_set = c_trap_none;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next     = S_TRAP;
                    w_trap_set = c_trap_mem;
                end
            end
            S_DECODE: begin
                case (opcode)
                    c_op_rtype:           w_next = S_EXEC_R;
                    c_op_itype:           w_next = S_EXEC_I;
                    c_op_load, c_op_store: w_next = S_MEM_ADDR;
                    c_op_beq, c_op_bne:   w_next = S_BRANCH;
                    c_op_jal:             w_next = S_JAL;
                    c_op_halt:            w_next = S_HALT;
                    default: begin
                        w_next     = S_TRAP;
                        w_trap_set = c_trap_illegal;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (opcode == c_op_store) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    w_next = (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (w_expired) begin
                    w_next     = S_TRAP;
                    w_trap_set = c_trap_mem;
                end
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: w_next = S_FETCH;
            S_HALT, S_TRAP: w_next = r_state;
            default: w_next = S_IDLE;
        endcase
    end

    // Control word is registered from the next state; only ready/zero qualify it afterwards
    always_ff @(negedge clk_n or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ctl        <= '0;
            r_trap_cause <= c_trap_none;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_decode(w_next);
            if (w_trap_set != c_trap_none) begin
                r_trap_cause <= w_trap_set;
            end
        end
    end

    assign w_clr = (w_next != r_state);
    assign w_inc = r_ctl.rdy_gated & ~mem_ready;

    mc_wait_timer #(
        .TO_W        (TO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_n   (clk_n),
        .rst     (rst),
        .clr     (w_clr),
        .inc     (w_inc),
        .expired (w_expired)
    );

    assign w_rdy_ok = ~r_ctl.rdy_gated | mem_ready;

    assign pc_en      = r_ctl.pc_en & w_rdy_ok &
                        (~r_ctl.br_cond | (zero ^ (opcode == c_op_bne)));
    assign ir_en      = r_ctl.ir_en & w_rdy_ok;
    assign mdr_en     = r_ctl.mdr_en & w_rdy_ok;
    assign instr_done = r_ctl.instr_done & w_rdy_ok;
    assign a_en       = r_ctl.a_en;
    assign b_en       = r_ctl.b_en;
    assign aluout_en  = r_ctl.aluout_en;
    assign rf_we      = r_ctl.rf_we;
    assign mem_req    = r_ctl.mem_req;
    assign mem_we     = r_ctl.mem_we;
    assign iord       = r_ctl.iord;
    assign alu_src_a  = r_ctl.alu_src_a;
    assign alu_src_b  = r_ctl.alu_src_b;
    assign alu_op     = r_ctl.alu_op;
    assign pc_src     = r_ctl.pc_src;
    assign wb_sel     = r_ctl.wb_sel;
    assign halted     = r_ctl.halted;
    assign trap_cause = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Scoreboard bench for mc_ctrl_fsm using directed per-cycle vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

    localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_EXEC_R = 3, T_EXEC_I = 4;
    localparam int T_ALU_WB = 5, T_MEM_ADDR = 6, T_MEM_RD = 7, T_MEM_WB = 8, T_MEM_WR = 9;
    localparam int T_BRANCH = 10, T_JAL = 11, T_HALT = 12, T_TRAP = 13;

    typedef struct packed {
        logic       pc_en, ir_en, mdr_en, a_en, b_en, aluout_en, rf_we;
        logic       mem_req, mem_we, iord, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src, wb_sel;
        logic       halted;
        logic [1:0] trap_cause;
        logic       instr_done;
    } obs_t;

    localparam int OW = $bits(obs_t);

    typedef struct {
        logic [OW-1:0] v;
        logic [OW-1:0] m;
        int            st;
        int            idx;
    } exp_t;

    logic       clk_n = 1'b1;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_en, mdr_en, a_en, b_en, aluout_en, rf_we;
    logic       mem_req, mem_we, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src, wb_sel;
    logic       halted;
    logic [1:0] trap_cause;
    logic       instr_done;

    logic [OW-1:0] obs;
    exp_t          sb_q[$];
    exp_t          mon_x;
    logic [1:0]    exp_tc;
    int            n_issued = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk_n = ~clk_n;

    mc_ctrl_fsm dut (
        .clk_n      (clk_n),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_en      (ir_en),
        .mdr_en     (mdr_en),
        .a_en       (a_en),
        .b_en       (b_en),
        .aluout_en  (aluout_en),
        .rf_we      (rf_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .wb_sel     (wb_sel),
        .halted     (halted),
        .trap_cause (trap_cause),
        .instr_done (instr_done)
    );

    assign obs = {pc_en, ir_en, mdr_en, a_en, b_en, aluout_en, rf_we, mem_req, mem_we,
                  iord, alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, halted,
                  trap_cause, instr_done};

    // Expected outputs for one cycle spent in state st with the given inputs
    function automatic void model(input int st, input logic rdy, input logic zr,
                                  input logic [3:0] op, input logic [1:0] tc,
                                  output logic [OW-1:0] ev, output logic [OW-1:0] mv);
        obs_t e;
        obs_t m;
        e = '0;
        m = '0;
        {m.pc_en, m.ir_en, m.mdr_en, m.a_en, m.b_en, m.aluout_en, m.rf_we} = '1;
        {m.mem_req, m.mem_we, m.halted, m.trap_cause, m.instr_done} = '1;
        case (st)
            T_FETCH: begin
                e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.ir_en = rdy; e.pc_en = rdy;
                m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1; m.pc_src = '1;
            end
            T_DECODE: begin
                e.a_en = 1'b1; e.b_en = 1'b1; e.aluout_en = 1'b1; e.alu_src_b = 2'd3;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1;
            end
            T_EXEC_R: begin
                e.alu_src_a = 1'b1; e.alu_op = 2'd2; e.aluout_en = 1'b1;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1;
            end
            T_EXEC_I: begin
                e.alu_src_b = 2'd2; e.alu_op = 2'd2; e.aluout_en = 1'b1;
                m.alu_src_b = '1; m.alu_op = '1;
            end
            T_ALU_WB: begin
                e.rf_we = 1'b1; e.instr_done = 1'b1; m.wb_sel = '1;
            end
            T_MEM_ADDR: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluout_en = 1'b1;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1;
            end
            T_MEM_RD: begin
                e.mem_req = 1'b1; e.iord = 1'b1; e.mdr_en = rdy; m.iord = 1'b1;
            end
            T_MEM_WB: begin
                e.rf_we = 1'b1; e.wb_sel = 2'd1; e.instr_done = 1'b1; m.wb_sel = '1;
            end
            T_MEM_WR: begin
                e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; e.instr_done = rdy;
                m.iord = 1'b1;
            end
            T_BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.instr_done = 1'b1;
                e.pc_en = (op == 4'h5) ? ~zr : zr;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1; m.pc_src = '1;
            end
            T_JAL: begin
                e.rf_we = 1'b1; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.pc_src = 2'd2;
                e.instr_done = 1'b1; m.wb_sel = '1; m.pc_src = '1;
            end
            T_HALT: e.halted = 1'b1;
            T_TRAP: begin
                e.halted = 1'b1; e.trap_cause = tc;
            end
            default: ;
        endcase
        ev = e;
        mv = m;
    endfunction

    task automatic step(input int st, input logic rdy, input logic zr);
        exp_t x;
        mem_ready = rdy;
        zero      = zr;
        model(st, rdy, zr, opcode, exp_tc, x.v, x.m);
        x.st  = st;
        x.idx = n_issued;
        n_issued++;
        sb_q.push_back(x);
        @(negedge clk_n);
        #1;
    endtask

    // rst rises mid-cycle, so the first IDLE check shows the asynchronous clear
    task automatic pulse_reset();
        rst    = 1'b1;
        exp_tc = 2'd0;
        step(T_IDLE, 1'b0, 1'b0);
        rst = 1'b0;
        step(T_IDLE, 1'b0, 1'b0);
    endtask

    always @(posedge clk_n) begin
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            n_checks++;
            if (((obs ^ mon_x.v) & mon_x.m) != '0) begin
                n_errors++;
                $display("FAIL step%0d state%0d: outputs got=%h expected=%h mask=%h",
                         mon_x.idx, mon_x.st, obs & mon_x.m, mon_x.v & mon_x.m, mon_x.m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        exp_tc    = 2'd0;
        @(negedge clk_n);
        #1;
        step(T_IDLE, 1'b0, 1'b0);
        rst = 1'b0;
        step(T_IDLE, 1'b0, 1'b0);

        // R-type, zero-wait memory
        opcode = 4'h0;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_EXEC_R, 1, 0); step(T_ALU_WB, 1, 0);
        // I-type
        opcode = 4'h1;
        step(T_FETCH, 1, 0); step(T_DECODE, 0, 0); step(T_EXEC_I, 1, 0); step(T_ALU_WB, 0, 0);
        // LOAD with three wait states in MEM_RD; ready elsewhere is ignored
        opcode = 4'h2;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_MEM_ADDR, 1, 0);
        for (int i = 0; i < 3; i++) step(T_MEM_RD, 0, 0);
        step(T_MEM_RD, 1, 0); step(T_MEM_WB, 1, 0);
        // STORE with one wait state
        opcode = 4'h3;
        step(T_FETCH, 1, 0); step(T_DECODE, 0, 0); step(T_MEM_ADDR, 0, 0);
        step(T_MEM_WR, 0, 0); step(T_MEM_WR, 1, 0);
        // Branches on both zero polarities
        opcode = 4'h4;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 1); step(T_BRANCH, 1, 1);
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_BRANCH, 1, 0);
        opcode = 4'h5;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 1); step(T_BRANCH, 1, 1);
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_BRANCH, 1, 0);
        // JAL
        opcode = 4'h6;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_JAL, 1, 0);
        // Ready arrives on the last permitted FETCH edge
        opcode = 4'h0;
        for (int i = 0; i < 14; i++) step(T_FETCH, 0, 0);
        step(T_FETCH, 1, 0); step(T_DECODE, 0, 0); step(T_EXEC_R, 0, 0); step(T_ALU_WB, 0, 0);
        // Timer must restart on MEM_RD entry after FETCH waits
        opcode = 4'h2;
        for (int i = 0; i < 5; i++) step(T_FETCH, 0, 0);
        step(T_FETCH, 1, 0); step(T_DECODE, 0, 0); step(T_MEM_ADDR, 0, 0);
        for (int i = 0; i < 14; i++) step(T_MEM_RD, 0, 0);
        step(T_MEM_RD, 1, 0); step(T_MEM_WB, 0, 0);
        // Reset while waiting in MEM_RD
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_MEM_ADDR, 1, 0);
        step(T_MEM_RD, 0, 0); step(T_MEM_RD, 0, 0);
        pulse_reset();
        // HALT is absorbing
        opcode = 4'hF;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0);
        for (int i = 0; i < 3; i++) step(T_HALT, 1, 0);
        pulse_reset();
        // Illegal opcode traps and stays quiet
        opcode = 4'h9;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0);
        exp_tc = 2'd1;
        for (int i = 0; i < 20; i++) step(T_TRAP, logic'(i[0]), 0);
        pulse_reset();
        // FETCH timeout
        opcode = 4'h0;
        for (int i = 0; i < 15; i++) step(T_FETCH, 0, 0);
        exp_tc = 2'd2;
        for (int i = 0; i < 3; i++) step(T_TRAP, 1, 0);
        pulse_reset();
        // MEM_WR timeout
        opcode = 4'h3;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_MEM_ADDR, 1, 0);
        for (int i = 0; i < 15; i++) step(T_MEM_WR, 0, 0);
        exp_tc = 2'd2;
        step(T_TRAP, 1, 0); step(T_TRAP, 0, 0);
        pulse_reset();
        // Normal operation resumes after reset
        opcode = 4'h1;
        step(T_FETCH, 1, 0); step(T_DECODE, 1, 0); step(T_EXEC_I, 1, 0); step(T_ALU_WB, 1, 0);

        @(negedge clk_n);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
